// File: rtl/write_through_buffer_pkg.sv
// Shared types for the write-through store buffer.
package write_through_buffer_pkg;

  // Kind of regfile write performed in a given cycle.
  typedef enum logic [1:0] {
    WR_NONE,
    WR_APPEND,
    WR_MERGE
  } wr_op_e;

endpackage

// File: rtl/write_through_buffer_regfile.sv
// Entry storage for the write-through buffer: one synchronous write port with
// per-byte data enables and one asynchronous read port.
module wtb_regfile
  import write_through_buffer_pkg::*;
#(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int NB      = 4,
  parameter int DEPTH_W = 2
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [NB-1:0]      wbe,
  input  logic [AW-1:0]      w_addr,
  input  logic [DW-1:0]      w_data,
  input  logic [NB-1:0]      w_strb,
  input  logic [DEPTH_W-1:0] raddr,
  output logic [AW-1:0]      r_addr,
  output logic [DW-1:0]      r_data,
  output logic [NB-1:0]      r_strb
);

  localparam int DEPTH = 2**DEPTH_W;

  logic [DEPTH-1:0][AW-1:0] addr_mem;
  logic [DEPTH-1:0][DW-1:0] data_mem;
  logic [DEPTH-1:0][NB-1:0] strb_mem;

  // Address and strobes are always rewritten whole; data only on enabled bytes.
  always_ff @(posedge clk) begin
    if (we) begin
      addr_mem[waddr] <= w_addr;
      strb_mem[waddr] <= w_strb;
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) data_mem[waddr][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  assign r_addr = addr_mem[raddr];
  assign r_data = data_mem[raddr];
  assign r_strb = strb_mem[raddr];

endmodule

// File: rtl/write_through_buffer.sv
// Store FIFO between the cache front-end and the AXI write channel.
// Optional write merging into the newest entry is enabled by WTB_MERGE_EN.
module write_through_buffer
  import write_through_buffer_pkg::*;
#(
  parameter int FE_ADDR_W = 32,
  parameter int FE_DATA_W = 32,
  parameter int DEPTH_W   = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   push,
  input  logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-1:0] push_addr,
  input  logic [FE_DATA_W-1:0]                   push_wdata,
  input  logic [FE_DATA_W/8-1:0]                 push_wstrb,
  output logic                                   full,
  output logic                                   empty,
  output logic [DEPTH_W:0]                       level,
  output logic                                   valid,
  output logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-1:0] addr,
  output logic [FE_DATA_W-1:0]                   wdata,
  output logic [FE_DATA_W/8-1:0]                 wstrb,
  input  logic                                   ready
);

  localparam int FE_NBYTES = FE_DATA_W/8;
  localparam int FE_BYTE_W = $clog2(FE_NBYTES);
  localparam int AW        = FE_ADDR_W - FE_BYTE_W;
  localparam int DEPTH     = 2**DEPTH_W;
  localparam int ENTRY_W   = AW + FE_DATA_W + FE_NBYTES;
  localparam logic [DEPTH_W:0] LVL_FULL = (DEPTH_W+1)'(DEPTH);

  logic [DEPTH_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_W:0]     level_q, level_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [FE_DATA_W-1:0] wdata_q, wdata_d;
  logic [FE_NBYTES-1:0] wstrb_q, wstrb_d;

  wr_op_e               wr_op;
  logic                 rd, merge_hit, we;
  logic [DEPTH_W-1:0]   waddr;
  logic [FE_NBYTES-1:0] wbe, w_strb;
  logic [AW-1:0]        rf_addr;
  logic [FE_DATA_W-1:0] rf_data;
  logic [FE_NBYTES-1:0] rf_strb;
  logic [ENTRY_W-1:0]   rd_entry;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign valid = ~empty;
  assign level = level_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign wstrb = wstrb_q;

  assign rd = valid & ready;

`ifdef WTB_MERGE_EN
  // Shadow of the newest entry's address/strobes, so the merge check does not
  // need a second regfile read port.
  logic [AW-1:0]        last_addr_q, last_addr_d;
  logic [FE_NBYTES-1:0] last_strb_q, last_strb_d;

  assign merge_hit = push & (level_q != '0) & ~(rd & (level_q == 1))
                   & (push_addr == last_addr_q);

  always_comb begin
    last_addr_d = last_addr_q;
    last_strb_d = last_strb_q;
    if (we) begin
      last_addr_d = push_addr;
      last_strb_d = w_strb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_addr_q <= '0;
      last_strb_q <= '0;
    end else begin
      last_addr_q <= last_addr_d;
      last_strb_q <= last_strb_d;
    end
  end
`else
  assign merge_hit = 1'b0;
`endif

  always_comb begin
    wr_op = WR_NONE;
    if (merge_hit)         wr_op = WR_MERGE;
    else if (push & ~full) wr_op = WR_APPEND;
    we = (wr_op != WR_NONE);

    // Appends write every data byte so stale bytes never leak out.
    waddr  = wptr_q;
    wbe    = '1;
    w_strb = push_wstrb;
`ifdef WTB_MERGE_EN
    if (wr_op == WR_MERGE) begin
      waddr  = wptr_q - 1'b1;
      wbe    = push_wstrb;
      w_strb = last_strb_q | push_wstrb;
    end
`endif
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;

    if (wr_op == WR_APPEND) wptr_d = wptr_q + 1'b1;
    if (rd) begin
      rptr_d  = rptr_q + 1'b1;
      addr_d  = rd_entry[ENTRY_W-1 -: AW];
      wdata_d = rd_entry[FE_NBYTES +: FE_DATA_W];
      wstrb_d = rd_entry[FE_NBYTES-1:0];
    end

    case ({wr_op == WR_APPEND, rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign rd_entry = {rf_addr, rf_data, rf_strb};

  wtb_regfile #(
    .AW      (AW),
    .DW      (FE_DATA_W),
    .NB      (FE_NBYTES),
    .DEPTH_W (DEPTH_W)
  ) u_regfile (
    .clk    (clk),
    .we     (we),
    .waddr  (waddr),
    .wbe    (wbe),
    .w_addr (push_addr),
    .w_data (push_wdata),
    .w_strb (w_strb),
    .raddr  (rptr_q),
    .r_addr (rf_addr),
    .r_data (rf_data),
    .r_strb (rf_strb)
  );

endmodule
